// File: rtl/regfile_pkg.sv
// Shared defaults and packing helpers for the register file with writeback scoreboard.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;
    localparam int RF_BYPASS = 1;

    localparam int RF_RD_ADDR_BUS_W = RF_NUM_RD * RF_ADDR_W;
    localparam int RF_RD_DATA_BUS_W = RF_NUM_RD * RF_DATA_W;

    // Low bit of lane k in a bus of w-bit lanes packed from bit 0 upward.
    function automatic int lane_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_track.sv
// Pending-writeback tracker: busy bits set by claims, cleared by port-B writes,
// plus the port-A hazard pulse and a registered busy population count.
module regfile_scoreboard_track
    import regfile_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic                     wa_hazard,
    output logic [ADDR_W:0]          busy_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] r_busy;
    logic [DEPTH-1:0] w_busy_nxt;
    logic [ADDR_W:0]  r_count;
    logic [ADDR_W:0]  w_count_nxt;
    logic             r_hazard;
    logic             w_hazard_nxt;

    // Clear before set so a same-cycle claim wins over the retiring writeback.
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (claim_en && (claim_addr != '0)) begin
            w_busy_nxt[claim_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Count the next-state vector so the registered count lines up with r_busy.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_count_nxt = w_count_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
        end
    end

    assign w_hazard_nxt = wa_en && (wa_addr != '0) && r_busy[wa_addr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy   <= '0;
            r_count  <= '0;
            r_hazard <= 1'b0;
        end else begin
            r_busy   <= w_busy_nxt;
            r_count  <= w_count_nxt;
            r_hazard <= w_hazard_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [ADDR_W-1:0] w_addr;
        assign w_addr     = rd_addr[lane_lo(k, ADDR_W) +: ADDR_W];
        assign rd_busy[k] = r_busy[w_addr];
    end

    assign wa_hazard  = r_hazard;
    assign busy_count = r_count;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read, dual-write register file (r0 hardwired to zero) with optional
// same-cycle write forwarding and a pending-writeback scoreboard.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = RF_NUM_RD,
    parameter int BYPASS = RF_BYPASS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wa_en,
    input  logic [ADDR_W-1:0]        wa_addr,
    input  logic [DATA_W-1:0]        wa_data,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     claim_en,
    input  logic [ADDR_W-1:0]        claim_addr,
    output logic                     wa_hazard,
    output logic [ADDR_W:0]          busy_count
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Port B is written last so it wins an address collision with port A.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (wa_en && (wa_addr != '0)) begin
                r_mem[wa_addr] <= wa_data;
            end
            if (wb_en && (wb_addr != '0)) begin
                r_mem[wb_addr] <= wb_data;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;

        assign w_addr = rd_addr[lane_lo(k, ADDR_W) +: ADDR_W];

        always_comb begin
            w_data = r_mem[w_addr];
            if (BYPASS != 0) begin
                if (wa_en && (wa_addr == w_addr)) begin
                    w_data = wa_data;
                end
                if (wb_en && (wb_addr == w_addr)) begin
                    w_data = wb_data;
                end
            end
            if (w_addr == '0) begin
                w_data = '0;
            end
        end

        assign rd_data[lane_lo(k, DATA_W) +: DATA_W] = w_data;
    end

    regfile_scoreboard_track #(
        .ADDR_W (ADDR_W),
        .NUM_RD (NUM_RD)
    ) u_track (
        .clk        (clk),
        .reset      (reset),
        .rd_addr    (rd_addr),
        .rd_busy    (rd_busy),
        .wa_en      (wa_en),
        .wa_addr    (wa_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .claim_en   (claim_en),
        .claim_addr (claim_addr),
        .wa_hazard  (wa_hazard),
        .busy_count (busy_count)
    );

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NUM_RD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = none.
REQ-005 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-006 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at bits [k*ADDR_W +: ADDR_W].
REQ-008 SHALL have port rd_data  out  NUM_RD*DATA_W  packed combinational read data, packed the same way.
REQ-009 SHALL have port rd_busy  out  NUM_RD  per-port flag: addressed register has a pending writeback.
REQ-010 SHALL have ports wa_en/wa_addr/wa_data  in  1/ADDR_W/DATA_W  write port A (ALU writeback).
REQ-011 SHALL have ports wb_en/wb_addr/wb_data  in  1/ADDR_W/DATA_W  write port B (load/multiply writeback).
REQ-012 SHALL have ports claim_en/claim_addr  in  1/ADDR_W  marks a register as pending port-B writeback.
REQ-013 SHALL have port wa_hazard  out  1  registered pulse: port A wrote a busy register.
REQ-014 SHALL have port busy_count  out  ADDR_W+1  number of busy registers.

Function
REQ-015 Register 0 SHALL always read 0, SHALL ignore writes and claims, and SHALL never be busy.
REQ-016 Enabled writes SHALL update the addressed register at the next rising edge.
REQ-017 If wa and wb target the same nonzero address in one cycle, port B's data SHALL be stored.
REQ-018 With BYPASS=1, a read whose address matches an enabled nonzero write SHALL return that write data in the same cycle, port B before port A; with BYPASS=0 it SHALL return the stored value.
REQ-019 A claim SHALL set the busy bit at the next edge; an enabled port-B write SHALL clear the busy bit of its address at the next edge.
REQ-020 A claim and a port-B write to the same address in the same cycle SHALL leave the bit set (new claim wins).
REQ-021 Port-A writes SHALL NOT change busy bits; a port-A write to a busy register SHALL still store its data and SHALL assert wa_hazard for exactly the following cycle.
REQ-022 rd_busy[k] SHALL reflect the stored busy bit of rd_addr port k combinationally, with no bypass of same-cycle claims or clears.
REQ-023 busy_count SHALL be a registered population count of the busy bits, consistent with the busy bits in the same cycle; maximum value 2**ADDR_W-1.
REQ-024 A claim of an already busy register SHALL be idempotent; busy_count SHALL NOT double-count.

Reset
REQ-025 On reset, all registers, all busy bits, wa_hazard and busy_count SHALL become 0 at that edge.
REQ-026 Reset SHALL take priority over any same-cycle write or claim.
REQ-027 Reset mid-operation SHALL discard outstanding claims; a later port-B write to such a register SHALL store data normally with no hazard.

Structure
REQ-028 Parameter defaults and the rd-port packing helper width constants SHALL live in shared package regfile_pkg.
REQ-029 The busy-bit vector, claim/clear logic, wa_hazard and busy_count SHALL be a sub-module regfile_scoreboard_track; storage and read muxing SHALL stay in the top module.
REQ-030 The design SHALL be synthesizable, use no latches, and scale to NUM_RD=4 without code edits.

Verification
REQ-031 Reset, then write wa r3=0x11111111; next cycle read r3 -> 0x11111111; read r0 -> 0; write wa r0=0xFFFFFFFF -> r0 still reads 0.
REQ-032 Same cycle: wa r5=0xAAAA0000 and wb r5=0x0000BBBB -> r5 stores 0x0000BBBB; with BYPASS=1 the same-cycle read of r5 returns 0x0000BBBB.
REQ-033 Claim r7 -> rd_busy on r7 is 1 and busy_count=1 next cycle; wb r7=0x5 -> busy clears, busy_count=0 and r7=0x5 the following cycle.
REQ-034 With r9 busy, wa r9=0x9 -> r9=0x9, wa_hazard=1 for exactly one cycle, busy stays 1.
REQ-035 In the same cycle, claim r4 and wb r4 -> busy stays 1; claim r4 again -> busy_count unchanged.
REQ-036 Claim r1, r2, r3, then assert reset -> all busy bits, busy_count and r1..r3 are 0; a subsequent wb r2=0x7 stores 0x7 and wa_hazard stays 0.
